// File: rtl/button_filter_pkg.sv
// Shared constants and helpers for the button_filter debouncer.
// Mode encodings and the per-channel counter width derivation live here.
package button_filter_pkg;

  localparam int MODE_SYMMETRIC = 0;
  localparam int MODE_STRETCH   = 1;

  // Counter only has to reach HOLD-1, so clog2(HOLD) bits suffice (min 1).
  function automatic int cnt_width(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/button_filter_chan.sv
// One debounce channel: 2-flop synchroniser, hold counter, filtered level
// and registered rise/fall pulses aligned with the new filtered level.
module button_filter_chan
  import button_filter_pkg::*;
#(
  parameter int HOLD      = 100000,
  parameter int MODE      = MODE_SYMMETRIC,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W   = cnt_width(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD - 1);

  logic             s1_q, s2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, fall_q;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (MODE == MODE_STRETCH && s2_q) begin
      // Stretch mode: a high sample asserts immediately and re-arms the release.
      out_d = 1'b1;
      cnt_d = '0;
    end else if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      out_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= RESET_VAL;
      s2_q   <= RESET_VAL;
      out_q  <= RESET_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      // Pulses are registered alongside out_q so they coincide with the new level.
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/button_filter.sv
// Multi-channel button/switch debouncer: one independent filter per input bit
// plus a combined change strobe.
module button_filter
  import button_filter_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int HOLD      = 100000,
  parameter int MODE      = MODE_SYMMETRIC,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    button_filter_chan #(
      .HOLD      (HOLD),
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_i   (in[g]),
      .out_o  (out[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  assign any_change = |(rise | fall);

endmodule

// File: doc/button_filter.md
BUTTON_FILTER -- requirements
Module: button_filter

Interface
- REQ-001 Parameter CHANNELS, default 4: number of independent input channels; legal range 1..32.
- REQ-002 Parameter HOLD, default 100000: consecutive stable cycles required to accept a level change; legal range 2..2^24.
- REQ-003 Parameter MODE, default 0: 0 = symmetric filter, 1 = stretch (fast assert, filtered release).
- REQ-004 Parameter RESET_VAL, default 0: level of every synchroniser stage and every `out` bit after reset.
- REQ-005 clk  input  1  single system clock; all logic on rising edge.
- REQ-006 rst_n  input  1  reset, synchronous, active-low.
- REQ-007 in  input  CHANNELS  raw asynchronous button/switch levels.
- REQ-008 out  output  CHANNELS  filtered level per channel.
- REQ-009 rise  output  CHANNELS  one-cycle pulse when the matching `out` bit goes 0->1.
- REQ-010 fall  output  CHANNELS  one-cycle pulse when the matching `out` bit goes 1->0.
- REQ-011 any_change  output  1  OR of all `rise` and `fall` bits, same cycle.

Function
- REQ-012 Each channel SHALL pass `in` through a 2-flop synchroniser (s1, s2); only s2 feeds the filter.
- REQ-013 Each channel SHALL hold a counter of width CNT_W = clog2(HOLD); counters never exceed HOLD-1 and never wrap.
- REQ-014 MODE 0: if s2 == out, counter <= 0; else if counter == HOLD-1, out <= s2 and counter <= 0; else counter increments.
- REQ-015 MODE 0: a clean level change on `in` SHALL appear on `out` exactly HOLD+2 cycles after the first edge that samples it.
- REQ-016 MODE 0: any glitch returning s2 to the `out` level before the count completes SHALL clear the counter; a subsequent change SHALL restart the full HOLD count.
- REQ-017 MODE 1: s2 == 1 SHALL set out <= 1 and clear the counter in the same cycle (latency 2 cycles from `in`).
- REQ-018 MODE 1: release SHALL follow REQ-014 (s2 == 0 for HOLD consecutive cycles clears `out`); any s2 == 1 during release restarts the count.
- REQ-019 `rise`/`fall` SHALL be registered and asserted in the same cycle that the new `out` value is first visible; each lasts exactly one cycle.
- REQ-020 `rise` and `fall` of one channel SHALL never both be high; different channels may pulse in the same cycle.
- REQ-021 Channels SHALL be fully independent; activity on one channel SHALL not alter the timing of another.

Reset
- REQ-022 While rst_n == 0 at a rising edge: s1, s2, out <= RESET_VAL per bit; counters <= 0; rise, fall, any_change <= 0.
- REQ-023 Reset mid-count SHALL discard the partial count; no rise/fall pulse SHALL be generated by reset or on the first cycle after it.
- REQ-024 If `in` differs from RESET_VAL on release of reset, the change SHALL be accepted per REQ-015/REQ-017 timing measured from the first non-reset edge.

Structure
- REQ-025 Shared package button_filter_pkg SHALL hold MODE_SYMMETRIC = 0, MODE_STRETCH = 1 and the CNT_W derivation function.
- REQ-026 One sub-module, button_filter_chan (synchroniser, counter, out/rise/fall for one bit), SHALL be instantiated CHANNELS times by a generate loop; the top level adds only the any_change OR.

Verification (HOLD = 8, CHANNELS = 4 unless noted)
- REQ-027 MODE 0, in[0] 0->1 held: out[0] rises at edge 10 after change; rise[0] high for exactly that cycle; any_change high same cycle.
- REQ-028 MODE 0, in[1] high for 5 cycles then low, repeated 3 times: out[1] stays 0, no pulses; then high for 12 cycles: out[1] = 1 after 10 cycles.
- REQ-029 MODE 1, in[2] one-cycle high pulse: out[2] high 2 cycles later, stays high 8 more cycles, fall[2] pulses when it drops; re-pulse during release extends hold.
- REQ-030 rst_n low at count 5 of a pending change on in[3]: out[3] = RESET_VAL, no pulse; after release, change accepted 10 cycles after first non-reset edge.
- REQ-031 in[0] and in[3] change on the same edge, in opposite directions: rise[0] and fall[3] pulse in the same cycle; any_change high once.
- REQ-032 RESET_VAL = 1, CHANNELS = 1, HOLD = 2: out = 1 after reset; in held 0 gives out = 0 after 4 cycles and one fall pulse.
